regfile_ctrl: RTL and testbench
===============================

Name: regfile_ctrl

Overview:
Access controller for the 2-read/1-write register file. The file is built from two synchronous dual-port RAM copies: 16 x 8, one write port shared by both copies, 1-cycle read latency.
- Clears RAM contents after reset.
- Arbitrates two writeback requesters onto the single write port.
- Sequences paired reads and returns their data with an acknowledge.
- Enforces the hardwired-zero register r0.
- Sits between the CPU pipeline (decode and writeback stages) and the register-file RAM wrapper.

Parameters:
ADDR_W, 4, register address width
DATA_W, 8, register data width
DEPTH, 16, number of registers; must equal 2**ADDR_W

Ports:
clk  in  1  system clock; all state updates on rising edge
aclr_n  in  1  asynchronous active-low reset
wb0_req  in  1  writeback request, ALU stage (high priority)
wb0_addr  in  ADDR_W  destination register
wb0_data  in  DATA_W  write data
wb0_gnt  out  1  write accepted this cycle
wb1_req  in  1  writeback request, load stage (low priority)
wb1_addr  in  ADDR_W  destination register
wb1_data  in  DATA_W  write data
wb1_gnt  out  1  write accepted this cycle
rd_req  in  1  paired read request
rd_addr_1  in  ADDR_W  source register 1
rd_addr_2  in  ADDR_W  source register 2
rd_ack  out  1  rd_data_1/2 valid
rd_data_1  out  DATA_W  source 1 value
rd_data_2  out  DATA_W  source 2 value
ready  out  1  clear sequence finished; requests are accepted
ram_aclr  out  1  RAM output-register clear, active high, equal to ~aclr_n
ram_wren  out  1  RAM write enable
ram_wraddress  out  ADDR_W  RAM write address
ram_data  out  DATA_W  RAM write data
ram_rden_1  out  1  RAM read enable, copy 1
ram_rden_2  out  1  RAM read enable, copy 2
ram_rdaddress_1  out  ADDR_W  RAM read address, copy 1
ram_rdaddress_2  out  ADDR_W  RAM read address, copy 2
ram_q_1  in  DATA_W  RAM read data, copy 1
ram_q_2  in  DATA_W  RAM read data, copy 2

Behaviour:
- Reset (aclr_n low, asynchronous, any time):
  - state = S_CLEAR, clr_cnt = 0.
  - rd_ack = 0, rd_data_1/2 = 0, ready = 0, all gnt = 0.
  - Any pending read acknowledge is discarded.
- FSM S_CLEAR:
  - Each cycle: ram_wren = 1, ram_wraddress = clr_cnt, ram_data = 0; clr_cnt increments.
  - When clr_cnt == DEPTH-1, go to S_RUN next cycle. Clear takes exactly DEPTH cycles.
  - Requests are ignored: no gnt, no rd_ack.
- FSM S_RUN: ready = 1. S_RUN has no exit except reset.
- Write arbitration:
  - Combinational, same cycle. Fixed priority: wb0 over wb1.
  - wbX_gnt = wbX_req and won; at most one gnt per cycle.
  - The loser holds req, addr and data stable until granted.
  - Winner drives ram_wraddress and ram_data.
  - ram_wren = winner exists and winner address != 0. A write to r0 is granted but discarded.
- Reads:
  - A read accepted in cycle N (rd_req and ready): ram_rden_1/2 = 1, ram_rdaddress_1/2 = rd_addr_1/2 in cycle N.
  - In cycle N+1: rd_ack = 1, rd_data_x = ram_q_x.
  - Registered address 0 forces rd_data_x = 0.
  - One read per cycle, fully pipelined; back-to-back requests give back-to-back acks.
  - rd_data_x holds its last value when rd_ack = 0.
- Read-during-write to the same address in the same cycle:
  - The RAM returns old data.
  - Behaviour with or without forwarding is set by WR_BYPASS_EN.
- Simultaneous wb0 write, wb1 write and read are legal in any combination.

Optional Feature:
WR_BYPASS_EN
- Defined: the controller registers the cycle-N granted write (address, data, valid).
  - If a read address matched it (non-zero), rd_data_x in N+1 = forwarded write data.
  - Reads always see writes granted in the same cycle.
- Undefined: no forwarding logic; rd_data_x in N+1 = ram_q_x (old value).
  - The pipeline must stall one cycle on this hazard.

Decomposition:
- Package regfile_pkg holds:
  - ADDR_W, DATA_W, DEPTH defaults
  - ZERO_REG = 0
  - FSM state encoding S_CLEAR = 1'b0, S_RUN = 1'b1
- One natural sub-module: rf_wr_arb, a fixed-priority 2:1 grant plus address/data mux, instantiated once.

Test Plan:
- Release aclr_n -> ram_wren = 1 for 16 cycles, addresses 0..15, data 0x00. ready rises the following cycle. Read r5 -> rd_ack next cycle, rd_data_1 = 0x00.
- wb0 writes r3 = 0x5A, then read rd_addr_1 = 3, rd_addr_2 = 3 -> wb0_gnt same cycle; one cycle after the read, rd_ack = 1 and both data = 0x5A.
- wb0 writes r4 = 0x11 and wb1 writes r7 = 0x22 in the same cycle -> cycle 1: gnt0 = 1, gnt1 = 0; cycle 2: gnt1 = 1. Reads then return 0x11 and 0x22.
- wb1 writes r0 = 0xFF -> wb1_gnt = 1, ram_wren = 0. Read r0 -> 0x00.
- Same-cycle write r9 = 0xA5 and read r9 (r9 previously 0x00) -> rd_data = 0xA5 with WR_BYPASS_EN, 0x00 without it.
- Pull aclr_n low during the cycle after rd_req -> rd_ack stays 0, ready = 0, clear sequence restarts. A read after ready of a previously written register returns 0x00.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file access controller.
// The optional macro WR_BYPASS_EN (used in regfile_ctrl) adds same-cycle write forwarding.
package regfile_pkg;

    localparam int ADDR_W   = 4;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int ZERO_REG = 0;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/rf_wr_arb.sv
// Fixed-priority 2:1 writeback arbiter: port 0 always wins over port 1.
// Purely combinational; the winner's address and data are muxed out.
module rf_wr_arb #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              win_valid,
    output logic [ADDR_W-1:0] win_addr,
    output logic [DATA_W-1:0] win_data
);

    // Grant and mux: port 0 wins whenever it requests.
    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        win_valid = 1'b0;
        win_addr  = addr1;
        win_data  = data1;
        if (req0) begin
            gnt0      = 1'b1;
            win_valid = 1'b1;
            win_addr  = addr0;
            win_data  = data0;
        end else if (req1) begin
            gnt1      = 1'b1;
            win_valid = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_ctrl.sv
// Access controller for a 2-read/1-write register file built from two
// dual-port RAM copies (1-cycle read latency). Clears the RAM after reset,
// arbitrates two writeback ports, pipelines paired reads, forces r0 to zero.
// Optional macro WR_BYPASS_EN: forward a write granted in the same cycle as
// a read to that read's returned data.
//
// Handshakes: a writeback port is accepted in the cycle its wbX_gnt is high
// (req held stable until then); a read is accepted in any cycle with
// rd_req && ready and its data is valid exactly one cycle later with rd_ack.
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int DEPTH  = regfile_pkg::DEPTH
) (
    input  logic              clk,
    input  logic              aclr_n,
    input  logic              wb0_req,
    input  logic [ADDR_W-1:0] wb0_addr,
    input  logic [DATA_W-1:0] wb0_data,
    output logic              wb0_gnt,
    input  logic              wb1_req,
    input  logic [ADDR_W-1:0] wb1_addr,
    input  logic [DATA_W-1:0] wb1_data,
    output logic              wb1_gnt,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [ADDR_W-1:0] rd_addr_2,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data_1,
    output logic [DATA_W-1:0] rd_data_2,
    output logic              ready,
    output logic              ram_aclr,
    output logic              ram_wren,
    output logic [ADDR_W-1:0] ram_wraddress,
    output logic [DATA_W-1:0] ram_data,
    output logic              ram_rden_1,
    output logic              ram_rden_2,
    output logic [ADDR_W-1:0] ram_rdaddress_1,
    output logic [ADDR_W-1:0] ram_rdaddress_2,
    input  logic [DATA_W-1:0] ram_q_1,
    input  logic [DATA_W-1:0] ram_q_2,
    output state_t            dbg_state
);

    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt;
    logic                win_valid;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                rd_accept;
    logic                rd_pend;
    logic [ADDR_W-1:0]   rd_a1_q, rd_a2_q;
    logic [DATA_W-1:0]   hold_1, hold_2;
    logic [DATA_W-1:0]   rd_val_1, rd_val_2;

    assign ram_aclr  = ~aclr_n;
    assign ready     = (state == S_RUN);
    assign dbg_state = state;

    // State register and clear-address counter.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            state   <= S_CLEAR;
            clr_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_CLEAR) clr_cnt <= clr_cnt + 1'b1;
        end
    end

    // Next state: leave the clear sweep after the last address; run forever.
    always_comb begin
        state_nxt = state;
        case (state)
            S_CLEAR: if (clr_cnt == LAST_ADDR) state_nxt = S_RUN;
            S_RUN:   state_nxt = S_RUN;
            default: state_nxt = S_CLEAR;
        endcase
    end

    rf_wr_arb #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_arb (
        .req0      (wb0_req & ready),
        .addr0     (wb0_addr),
        .data0     (wb0_data),
        .req1      (wb1_req & ready),
        .addr1     (wb1_addr),
        .data1     (wb1_data),
        .gnt0      (wb0_gnt),
        .gnt1      (wb1_gnt),
        .win_valid (win_valid),
        .win_addr  (win_addr),
        .win_data  (win_data)
    );

    // Write port: clear sweep owns it until ready, then the arbiter winner; r0 writes dropped.
    always_comb begin
        ram_wren      = 1'b0;
        ram_wraddress = win_addr;
        ram_data      = win_data;
        if (!ready) begin
            ram_wren      = 1'b1;
            ram_wraddress = clr_cnt;
            ram_data      = '0;
        end else begin
            ram_wren = win_valid && (win_addr != ZERO_ADDR);
        end
    end

    assign rd_accept       = rd_req & ready;
    assign ram_rden_1      = rd_accept;
    assign ram_rden_2      = rd_accept;
    assign ram_rdaddress_1 = rd_addr_1;
    assign ram_rdaddress_2 = rd_addr_2;

    // Read pipeline: remember which addresses were issued so r0 can be forced next cycle.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            rd_pend <= 1'b0;
            rd_a1_q <= '0;
            rd_a2_q <= '0;
        end else begin
            rd_pend <= rd_accept;
            if (rd_accept) begin
                rd_a1_q <= rd_addr_1;
                rd_a2_q <= rd_addr_2;
            end
        end
    end

`ifdef WR_BYPASS_EN
    logic              byp_v_q;
    logic [ADDR_W-1:0] byp_a_q;
    logic [DATA_W-1:0] byp_d_q;

    // Capture the write committed alongside a read so the read can see it.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            byp_v_q <= 1'b0;
            byp_a_q <= '0;
            byp_d_q <= '0;
        end else begin
            byp_v_q <= ready && ram_wren;
            byp_a_q <= ram_wraddress;
            byp_d_q <= ram_data;
        end
    end

    // Returned value: r0 is zero, a matching same-cycle write wins, else RAM.
    always_comb begin
        rd_val_1 = ram_q_1;
        rd_val_2 = ram_q_2;
        if (rd_a1_q == ZERO_ADDR)                  rd_val_1 = '0;
        else if (byp_v_q && rd_a1_q == byp_a_q)    rd_val_1 = byp_d_q;
        if (rd_a2_q == ZERO_ADDR)                  rd_val_2 = '0;
        else if (byp_v_q && rd_a2_q == byp_a_q)    rd_val_2 = byp_d_q;
    end
`else
    // Returned value: r0 is zero, else RAM (old data on a same-cycle write).
    always_comb begin
        rd_val_1 = ram_q_1;
        rd_val_2 = ram_q_2;
        if (rd_a1_q == ZERO_ADDR) rd_val_1 = '0;
        if (rd_a2_q == ZERO_ADDR) rd_val_2 = '0;
    end
`endif

    assign rd_ack    = rd_pend;
    assign rd_data_1 = rd_pend ? rd_val_1 : hold_1;
    assign rd_data_2 = rd_pend ? rd_val_2 : hold_2;

    // Hold the last returned data while no acknowledge is pending.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            hold_1 <= '0;
            hold_2 <= '0;
        end else if (rd_pend) begin
            hold_1 <= rd_val_1;
            hold_2 <= rd_val_2;
        end
    end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl: RAM model, directed stimulus, register-file model
// with a read-expectation queue, per-cycle compare, final summary.
module tb_regfile_ctrl;
    import regfile_pkg::*;

    localparam int AW = 4;
    localparam int DW = 8;
    localparam int NREG = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic aclr_n = 1'b0;
    always #5 clk = ~clk;

    logic          wb0_req = 0, wb1_req = 0, rd_req = 0;
    logic [AW-1:0] wb0_addr = '0, wb1_addr = '0, rd_addr_1 = '0, rd_addr_2 = '0;
    logic [DW-1:0] wb0_data = '0, wb1_data = '0;
    logic          wb0_gnt, wb1_gnt, rd_ack, ready, ram_aclr, ram_wren;
    logic          ram_rden_1, ram_rden_2;
    logic [DW-1:0] rd_data_1, rd_data_2, ram_data, ram_q_1, ram_q_2;
    logic [AW-1:0] ram_wraddress, ram_rdaddress_1, ram_rdaddress_2;
    state_t        dbg_state;

    regfile_ctrl dut (
        .clk(clk), .aclr_n(aclr_n),
        .wb0_req(wb0_req), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_gnt(wb0_gnt),
        .wb1_req(wb1_req), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_gnt(wb1_gnt),
        .rd_req(rd_req), .rd_addr_1(rd_addr_1), .rd_addr_2(rd_addr_2),
        .rd_ack(rd_ack), .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
        .ready(ready), .ram_aclr(ram_aclr), .ram_wren(ram_wren),
        .ram_wraddress(ram_wraddress), .ram_data(ram_data),
        .ram_rden_1(ram_rden_1), .ram_rden_2(ram_rden_2),
        .ram_rdaddress_1(ram_rdaddress_1), .ram_rdaddress_2(ram_rdaddress_2),
        .ram_q_1(ram_q_1), .ram_q_2(ram_q_2), .dbg_state(dbg_state)
    );

    // ---------------- RAM model: two copies, shared write, old-data read ----------------
    logic [DW-1:0] mem_1 [NREG];
    logic [DW-1:0] mem_2 [NREG];
    always @(posedge clk or posedge ram_aclr) begin
        if (ram_aclr) begin
            ram_q_1 <= '0;
            ram_q_2 <= '0;
        end else begin
            if (ram_rden_1) ram_q_1 <= mem_1[ram_rdaddress_1];
            if (ram_rden_2) ram_q_2 <= mem_2[ram_rdaddress_2];
            if (ram_wren) begin
                mem_1[ram_wraddress] <= ram_data;
                mem_2[ram_wraddress] <= ram_data;
            end
        end
    end

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    logic [2*DW-1:0] exp_q [$];
    logic [DW-1:0]   rf [NREG];
    int              run_cyc = 0;
    logic            ack_exp = 0;
    logic [DW-1:0]   last_1 = '0, last_2 = '0;
    logic            rdy_exp, w_en;
    logic [AW-1:0]   w_a;
    logic [DW-1:0]   w_d;
    logic [2*DW-1:0] pair;

    // Per-cycle compare against the register-file model, then commit the cycle.
    always @(negedge clk) begin
        if (!aclr_n) begin
            check("rst_ready", ready, 0);
            check("rst_ack", rd_ack, 0);
            check("rst_data", {rd_data_1, rd_data_2}, 0);
            check("rst_gnt", {wb0_gnt, wb1_gnt}, 0);
            check("rst_ram_aclr", ram_aclr, 1);
            run_cyc = 0;
            ack_exp = 0;
            last_1 = '0;
            last_2 = '0;
            exp_q.delete();
            for (int i = 0; i < NREG; i++) rf[i] = '0;
        end else begin
            rdy_exp = (run_cyc >= NREG);
            check("ram_aclr", ram_aclr, 0);
            check("ready", ready, rdy_exp);
            check("dbg_state", dbg_state, rdy_exp);
            w_en = 0; w_a = '0; w_d = '0;
            if (!rdy_exp) begin
                check("clr_wren", ram_wren, 1);
                check("clr_addr", ram_wraddress, run_cyc);
                check("clr_data", ram_data, 0);
                check("clr_gnt", {wb0_gnt, wb1_gnt}, 0);
            end else begin
                check("gnt0", wb0_gnt, wb0_req);
                check("gnt1", wb1_gnt, wb1_req && !wb0_req);
                if (wb0_req) begin w_a = wb0_addr; w_d = wb0_data; end
                else         begin w_a = wb1_addr; w_d = wb1_data; end
                w_en = (wb0_req || wb1_req) && (w_a != 0);
                check("wren", ram_wren, w_en);
                if (w_en) check("wr_addr_data", {ram_wraddress, ram_data}, {w_a, w_d});
            end
            check("rden", {ram_rden_1, ram_rden_2}, {2{rdy_exp && rd_req}});
            if (rdy_exp && rd_req)
                check("rdaddr", {ram_rdaddress_1, ram_rdaddress_2}, {rd_addr_1, rd_addr_2});
            check("rd_ack", rd_ack, ack_exp);
            if (ack_exp) begin
                if (exp_q.size() == 0) check("exp_q_empty", 1, 0);
                else begin
                    pair = exp_q.pop_front();
                    last_1 = pair[2*DW-1:DW];
                    last_2 = pair[DW-1:0];
                end
            end
            check("rd_data", {rd_data_1, rd_data_2}, {last_1, last_2});
            // commit this cycle's effects on the architectural register file
            ack_exp = rdy_exp && rd_req;
            if (rdy_exp && rd_req) begin
`ifdef WR_BYPASS_EN
                if (w_en) rf[w_a] = w_d;
`endif
                exp_q.push_back({(rd_addr_1 == 0) ? 8'h00 : rf[rd_addr_1],
                                 (rd_addr_2 == 0) ? 8'h00 : rf[rd_addr_2]});
            end
            if (w_en) rf[w_a] = w_d;
            if (run_cyc < NREG) run_cyc++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input logic w0r, input logic [AW-1:0] w0a, input logic [DW-1:0] w0d,
                        input logic w1r, input logic [AW-1:0] w1a, input logic [DW-1:0] w1d,
                        input logic rr, input logic [AW-1:0] ra1, input logic [AW-1:0] ra2);
        @(posedge clk);
        #1;
        wb0_req = w0r; wb0_addr = w0a; wb0_data = w0d;
        wb1_req = w1r; wb1_addr = w1a; wb1_data = w1d;
        rd_req = rr; rd_addr_1 = ra1; rd_addr_2 = ra2;
        @(negedge clk);
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1 aclr_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- directed test sequence ----------------
    initial begin
        int k;
        repeat (3) @(posedge clk);
        release_reset();                 // clear cycle 0
        for (int i = 1; i < NREG; i++) idle();
        check("lit_ready_last_clear", ready, 0);
        idle();
        check("lit_ready_rise", ready, 1);

        // read r5 after clear
        step(0, 0, 0, 0, 0, 0, 1, 5, 5);
        idle();
        check("lit_r5_ack", rd_ack, 1);
        check("lit_r5_data", rd_data_1, 8'h00);

        // wb0 writes r3 then paired read of r3
        step(1, 3, 8'h5A, 0, 0, 0, 0, 0, 0);
        check("lit_w3_gnt0", wb0_gnt, 1);
        step(0, 0, 0, 0, 0, 0, 1, 3, 3);
        idle();
        check("lit_r3_ack", rd_ack, 1);
        check("lit_r3_data", {rd_data_1, rd_data_2}, 16'h5A5A);

        // simultaneous writebacks, wb1 holds until granted
        step(1, 4, 8'h11, 1, 7, 8'h22, 0, 0, 0);
        check("lit_both_gnt", {wb0_gnt, wb1_gnt}, 2'b10);
        step(0, 0, 0, 1, 7, 8'h22, 0, 0, 0);
        check("lit_wb1_gnt", {wb0_gnt, wb1_gnt}, 2'b01);
        step(0, 0, 0, 0, 0, 0, 1, 4, 7);
        idle();
        check("lit_r4_r7", {rd_data_1, rd_data_2}, 16'h1122);
        idle();
        check("lit_hold", {rd_ack, rd_data_1, rd_data_2}, {1'b0, 16'h1122});

        // write to r0 is granted but dropped
        step(0, 0, 0, 1, 0, 8'hFF, 0, 0, 0);
        check("lit_r0_gnt_wren", {wb1_gnt, ram_wren}, 2'b10);
        step(0, 0, 0, 0, 0, 0, 1, 0, 3);
        idle();
        check("lit_r0_data", {rd_data_1, rd_data_2}, 16'h005A);

        // same-cycle write and read of r9
        step(1, 9, 8'hA5, 0, 0, 0, 1, 9, 9);
        idle();
`ifdef WR_BYPASS_EN
        check("lit_r9_rdw", {rd_data_1, rd_data_2}, 16'hA5A5);
`else
        check("lit_r9_rdw", {rd_data_1, rd_data_2}, 16'h0000);
`endif
        step(0, 0, 0, 0, 0, 0, 1, 9, 0);
        idle();
        check("lit_r9_after", {rd_data_1, rd_data_2}, 16'hA500);

        // back-to-back reads plus a low-priority write in the middle
        step(0, 0, 0, 0, 0, 0, 1, 3, 4);
        step(0, 0, 0, 1, 12, 8'h3C, 1, 7, 9);
        check("lit_b2b_ack1", rd_data_1, 8'h5A);
        step(0, 0, 0, 0, 0, 0, 1, 12, 12);
        check("lit_b2b_ack2", {rd_ack, rd_data_1}, {1'b1, 8'h22});
        idle();
        check("lit_b2b_ack3", {rd_ack, rd_data_2}, {1'b1, 8'h3C});

        // reset during the cycle after a read request
        step(0, 0, 0, 0, 0, 0, 1, 3, 3);
        @(posedge clk);
        #2;
        aclr_n = 1'b0;
        rd_req = 1'b0;
        @(negedge clk);
        check("lit_rst_ack", {rd_ack, ready}, 2'b00);
        repeat (2) @(posedge clk);
        release_reset();
        k = 0;
        while (!ready && k < 40) begin
            idle();
            k++;
        end
        check("lit_reclear_ready", ready, 1);
        check("lit_reclear_cycles", k, NREG);
        step(0, 0, 0, 0, 0, 0, 1, 3, 7);
        idle();
        check("lit_reclear_data", {rd_ack, rd_data_1, rd_data_2}, {1'b1, 16'h0000});

        repeat (2) idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    // Global time limit so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

endmodule
